product_bcd_conv: RTL and testbench
===================================

# product_bcd_conv

Sequential binary-to-BCD converter that sits directly downstream of the signed sequential multiplier. It takes the 15-bit unsigned magnitude and the sign bit the multiplier produces and converts the magnitude to five packed BCD digits by shift-and-add-3 (double dabble), one bit per clock. A sign and a leading-digit blank mask are presented alongside the digits for the display driver.

## Interface
Parameters:
- W, 15, width of the binary magnitude input.
- DIGITS, 5, number of BCD digits produced. Must satisfy 10^DIGITS > 2^W − 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request conversion; sampled only in IDLE.
- bin_in  input  W  unsigned magnitude (multiplier product).
- sign_in  input  1  sign of the result (multiplier sign).
- busy  output  1  high while a conversion is in progress.
- valid  output  1  one-cycle pulse when new results are presented.
- bcd_out  output  4*DIGITS  packed BCD; digit i at bits [4i+3:4i]; digit 0 is the units digit.
- sign_out  output  1  registered sign; 1 means negative.
- blank  output  DIGITS  per-digit blank flags (see Configuration).

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: if start=1 at a rising edge, capture bin_in into a W-bit shift register, capture sign_in, clear the 4*DIGITS scratch register, load bit counter with W, go to SHIFT. Otherwise hold.
- SHIFT: each cycle, for every scratch digit ≥ 5 add 3 (4-bit, no carry out of the digit), then shift {scratch, binreg} left by one, feeding the binreg MSB into scratch bit 0. Decrement the counter; when it would reach 0, go to DONE.
- DONE: load bcd_out from scratch; sign_out = captured sign AND (magnitude ≠ 0), i.e. negative zero is reported as positive; update blank; assert valid for this cycle; return to IDLE.
- start while busy (SHIFT or DONE) is ignored; no queuing.
- start held high continuously yields back-to-back conversions, a new one beginning in the IDLE cycle after each DONE.
- bcd_out, sign_out and blank hold their values until the next DONE; they never show intermediate scratch values.
- Every digit of bcd_out is always in range 0–9.

## Timing
- Reset (rst_n low, asynchronous): state IDLE; busy=0, valid=0, bcd_out=0, sign_out=0, blank=0; internal registers cleared.
- start sampled at edge 0 → busy=1 after edge 0; shift operations occur at edges 1..W; DONE entered after edge W; outputs updated and valid=1 after edge W+1, with busy=0 from edge W+1. Latency start→valid: W+1 cycles (16 with defaults).
- Minimum spacing between accepted starts: W+2 cycles.
- valid is exactly one cycle wide.
- Reset asserted mid-conversion aborts it: no valid pulse, all outputs return to reset values immediately.
- bin_in and sign_in only need to be stable at the edge where start is accepted.

## Configuration
- Macro BCD_LEADING_BLANK_EN.
- Defined: in DONE, blank[i]=1 for every digit i above the most significant nonzero digit; blank[0] is always 0, so a zero result shows a single “0”. bcd_out digit values are unaffected.
- Not defined: blank is tied to all zeros; the blanking logic is not built.

## Test plan
- bin_in=16256, sign_in=0, start pulse → valid after 16 cycles, bcd_out=0x16256, sign_out=0, blank=00000.
- bin_in=16384 (0x4000), sign_in=1 → bcd_out=0x16384, sign_out=1; busy high for exactly 16 cycles.
- bin_in=0, sign_in=1 → bcd_out=0x00000, sign_out=0; blank=11110 with BCD_LEADING_BLANK_EN, 00000 without.
- bin_in=42, sign_in=1 → bcd_out=0x00042, sign_out=1; a second start with bin_in=99 issued 5 cycles later is ignored and no extra valid appears.
- start held high, bin_in=9999 then 7 → two valid pulses 17 cycles apart with 0x09999 then 0x00007; blank=10000 then 11110 with the macro.
- rst_n pulsed low at cycle 8 of a conversion of 12345 → outputs zero immediately, no valid; a fresh start then yields 0x12345.

Source files
------------

// File: rtl/product_bcd_conv.sv
// product_bcd_conv
// Sequential binary-to-BCD converter for the signed multiplier's product.
// It converts the W-bit unsigned magnitude to DIGITS packed BCD digits using
// shift-and-add-3 (double dabble), one bit per clock.
// The sign is registered, and negative zero is reported as positive.
// Optional feature macro: BCD_LEADING_BLANK_EN. When it is defined, the
// converter builds leading-digit blank flags. When it is undefined, blank is
// tied to zero.

module product_bcd_conv #(
    parameter int W      = 15,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [W-1:0]          bin_in,
    input  logic                  sign_in,
    output logic                  busy,
    output logic                  valid,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  sign_out,
    output logic [DIGITS-1:0]     blank
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;

    logic [W-1:0]    bin_reg;
    logic [BW-1:0]   scratch;
    logic [CW-1:0]   count;
    logic            sign_reg;

    logic [BW-1:0]   adjusted;
    logic [BW+W-1:0] combined;
    logic [BW-1:0]   scratch_shifted;
    logic [W-1:0]    bin_shifted;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. SHIFT leaves on the last bit, when the counter is about to reach zero.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (count == CW'(1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: busy covers both SHIFT and DONE.
    always_comb begin
        busy = (state != IDLE);
    end

    // Add 3 to every digit >= 5, then shift {scratch, bin_reg} left by one bit.
    always_comb begin
        adjusted = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
        combined        = {adjusted, bin_reg} << 1;
        scratch_shifted = combined[BW+W-1:W];
        bin_shifted     = combined[W-1:0];
    end

    // Datapath registers: capture the operands on start and step once per SHIFT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_reg  <= '0;
            scratch  <= '0;
            count    <= '0;
            sign_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_reg  <= bin_in;
                        sign_reg <= sign_in;
                        scratch  <= '0;
                        count    <= CW'(W);
                    end
                end
                SHIFT: begin
                    bin_reg <= bin_shifted;
                    scratch <= scratch_shifted;
                    count   <= count - CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers: load only in DONE, so intermediate scratch values are never visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid    <= 1'b0;
            bcd_out  <= '0;
            sign_out <= 1'b0;
        end else begin
            valid <= (state == DONE);
            if (state == DONE) begin
                bcd_out  <= scratch;
                sign_out <= sign_reg & (|scratch);
            end
        end
    end

`ifdef BCD_LEADING_BLANK_EN
    logic [DIGITS-1:0] blank_next;
    logic              upper_zero;

    // Blank each digit above the most significant nonzero digit; the units digit always shows.
    always_comb begin
        blank_next = '0;
        upper_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            upper_zero    = upper_zero & (scratch[4*i +: 4] == 4'd0);
            blank_next[i] = upper_zero;
        end
    end

    // Blank flags update together with the digits in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank <= '0;
        end else if (state == DONE) begin
            blank <= blank_next;
        end
    end
`else
    assign blank = '0;
`endif

endmodule

// File: tb/tb_product_bcd_conv.sv
// tb_product_bcd_conv
// This bench drives a directed sequence of conversions into product_bcd_conv.
// When a conversion starts, the bench pushes the expected digits, sign and blank
// flags to a queue. When valid pulses, it pops the entry and compares it.
// The blank expectation follows BCD_LEADING_BLANK_EN.

module tb_product_bcd_conv;

    localparam int W      = 15;
    localparam int DIGITS = 5;

    typedef struct {
        logic [4*DIGITS-1:0] bcd;
        logic                sign;
        logic [DIGITS-1:0]   blank;
    } expect_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic [W-1:0]        bin_in;
    logic                sign_in;
    logic                busy;
    logic                valid;
    logic [4*DIGITS-1:0] bcd_out;
    logic                sign_out;
    logic [DIGITS-1:0]   blank;

    expect_t sb[$];
    int      nCompared   = 0;
    int      nMismatched = 0;
    int      cycle       = 0;

    product_bcd_conv #(.W(W), .DIGITS(DIGITS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bin_in   (bin_in),
        .sign_in  (sign_in),
        .busy     (busy),
        .valid    (valid),
        .bcd_out  (bcd_out),
        .sign_out (sign_out),
        .blank    (blank)
    );

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    // Count rising edges so the bench can measure the spacing between valid pulses.
    always @(posedge clk) cycle++;

    function automatic logic [4*DIGITS-1:0] toBcd(input int v);
        logic [4*DIGITS-1:0] r;
        int                  t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [DIGITS-1:0] toBlank(input int v);
        logic [DIGITS-1:0] r;
        r = '0;
`ifdef BCD_LEADING_BLANK_EN
        for (int i = 1; i < DIGITS; i++) begin
            int p;
            p = 1;
            for (int k = 0; k < i; k++) p = p * 10;
            r[i] = (v < p);
        end
`endif
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pushExpect(input int v, input logic s);
        expect_t e;
        e.bcd   = toBcd(v);
        e.sign  = s && (v != 0);
        e.blank = toBlank(v);
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input int v, input logic s, input bit doPush);
        @(negedge clk);
        start   = 1'b1;
        bin_in  = W'(v);
        sign_in = s;
        if (doPush) pushExpect(v, s);
    endtask

    // Wait for valid, counting busy samples. Optionally inject a second start at sample injectAt.
    task automatic waitValid(input int injectAt, input int injBin, output int lat, output int busyCnt);
        bit seen;
        seen    = 1'b0;
        lat     = -1;
        busyCnt = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            lat++;
            if (lat == 0) start = 1'b0;
            if (lat == injectAt) begin
                start   = 1'b1;
                bin_in  = W'(injBin);
                sign_in = 1'b0;
            end else if (lat == injectAt + 1) begin
                start = 1'b0;
            end
            if (busy === 1'b1) busyCnt++;
            if (valid === 1'b1) seen = 1'b1;
        end
        if (!seen) checkOutput("valid_timeout", 32'(valid), 32'd1);
    endtask

    // Scoreboard: every valid pulse pops and checks one expected result.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && valid === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_valid", 32'(valid), 32'd0);
            end else begin
                expect_t e;
                e = sb.pop_front();
                checkOutput("bcd_out", 32'(bcd_out), 32'(e.bcd));
                checkOutput("sign_out", 32'(sign_out), 32'(e.sign));
                checkOutput("blank", 32'(blank), 32'(e.blank));
            end
        end
    end

    // Directed test sequence.
    initial begin
        int lat;
        int busyCnt;
        int t1;
        int t2;
        bit seen;

        rst_n   = 1'b0;
        start   = 1'b0;
        bin_in  = '0;
        sign_in = 1'b0;
        t1      = 0;
        t2      = 0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_valid", 32'(valid), 32'd0);
        checkOutput("rst_bcd", 32'(bcd_out), 32'd0);
        checkOutput("rst_sign", 32'(sign_out), 32'd0);
        checkOutput("rst_blank", 32'(blank), 32'd0);
        rst_n = 1'b1;

        $display("[TB] conversion of 16256");
        applyStimulus(16256, 1'b0, 1'b1);
        waitValid(-5, 0, lat, busyCnt);
        checkOutput("latency_16256", 32'(lat), 32'd16);
        @(negedge clk);
        checkOutput("valid_width", 32'(valid), 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("bcd_hold", 32'(bcd_out), 32'h16256);

        $display("[TB] conversion of 16384, negative");
        applyStimulus(16384, 1'b1, 1'b1);
        waitValid(-5, 0, lat, busyCnt);
        checkOutput("busy_cycles", 32'(busyCnt), 32'd16);
        checkOutput("busy_low_at_valid", 32'(busy), 32'd0);

        $display("[TB] negative zero");
        applyStimulus(0, 1'b1, 1'b1);
        waitValid(-5, 0, lat, busyCnt);

        $display("[TB] maximum magnitude");
        applyStimulus(32767, 1'b1, 1'b1);
        waitValid(-5, 0, lat, busyCnt);

        $display("[TB] start while busy is ignored");
        applyStimulus(42, 1'b1, 1'b1);
        waitValid(4, 99, lat, busyCnt);
        checkOutput("latency_42", 32'(lat), 32'd16);
        repeat (25) @(negedge clk);
        checkOutput("no_extra_valid", 32'(sb.size()), 32'd0);

        $display("[TB] start held high, back-to-back");
        @(negedge clk);
        start   = 1'b1;
        bin_in  = W'(9999);
        sign_in = 1'b0;
        pushExpect(9999, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                seen   = 1'b1;
                t1     = cycle;
                bin_in = W'(7);
                pushExpect(7, 1'b0);
            end
        end
        if (!seen) checkOutput("valid_timeout_b2b1", 32'(valid), 32'd1);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                seen  = 1'b1;
                t2    = cycle;
                start = 1'b0;
            end
        end
        if (!seen) checkOutput("valid_timeout_b2b2", 32'(valid), 32'd1);
        start = 1'b0;
        checkOutput("b2b_spacing", 32'(t2 - t1), 32'd17);

        $display("[TB] reset mid-conversion");
        applyStimulus(12345, 1'b1, 1'b0);
        repeat (8) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_valid", 32'(valid), 32'd0);
        checkOutput("abort_bcd", 32'(bcd_out), 32'd0);
        checkOutput("abort_sign", 32'(sign_out), 32'd0);
        checkOutput("abort_blank", 32'(blank), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        applyStimulus(12345, 1'b0, 1'b1);
        waitValid(-5, 0, lat, busyCnt);
        checkOutput("latency_12345", 32'(lat), 32'd16);

        repeat (3) @(negedge clk);
        checkOutput("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
